pipeline_controller: RTL

Hazard, flag and sequencing controller for the 16-bit five-stage pipelined core. It tracks the opcode and destination of the instructions in EX, MEM and WB. From that state it generates load-use stalls, jump flushes, operand-forwarding selects and memory-wait freezes, and it owns the architectural status flags ZF/GF/LF. It sits beside the Decode/Execute/Memory stages and drives their pipeline-register enables.

---
 rtl/pipeline_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// pipeline_controller: hazard, forwarding, flag and freeze control
// for the 16-bit five-stage core.
module pipeline_controller #(
    parameter int IDX_W = 6,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_op,
    input  logic [IDX_W-1:0] id_src1,
    input  logic [IDX_W-1:0] id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [IDX_W-1:0] id_dest,
    input  logic             ex_cmp_zero,
    input  logic             ex_cmp_less,
    input  logic             ex_cmp_greater,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ex_bubble,
    output logic             take_jump,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             zf,
    output logic             gf,
    output logic             lf,
    output logic             wb_we,
    output logic [IDX_W-1:0] wb_dest,
    output logic [1:0]       state
);

    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SHLLI  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SHRLI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JUMP   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JUMPL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_JUMPG  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_JUMPE  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_JUMPNE = OP_W'(10);
    localparam logic [OP_W-1:0] OP_CMP    = OP_W'(11);
    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_LOADI  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_MOV    = OP_W'(15);

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [IDX_W-1:0] dest;
        logic [IDX_W-1:0] src1;
        logic [IDX_W-1:0] src2;
        logic             use1;
        logic             use2;
    } rec_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    function automatic logic f_writes(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI,
            OP_LOAD, OP_LOADI, OP_MOV: f_writes = 1'b1;
            default:                   f_writes = 1'b0;
        endcase
    endfunction

    // A LOAD in MEM has no result yet, so only WB can supply it.
    function automatic logic [1:0] f_fwd(
        input logic             reads,
        input logic [IDX_W-1:0] src,
        input rec_t             mem_r,
        input rec_t             wb_r
    );
        f_fwd = 2'b00;
        if (reads) begin
            if (mem_r.valid && f_writes(mem_r.op) &&
                mem_r.op != OP_LOAD && mem_r.dest == src)
                f_fwd = 2'b01;
            else if (wb_r.valid && f_writes(wb_r.op) && wb_r.dest == src)
                f_fwd = 2'b10;
        end
    endfunction

    rec_t   r_ex;
    rec_t   r_mem;
    rec_t   r_wb;
    logic   r_zf;
    logic   r_gf;
    logic   r_lf;
    state_t r_state;
    state_t w_state_nxt;

    logic   w_mem_busy;
    logic   w_jump_cond;
    logic   w_jump_hit;
    logic   w_hit1;
    logic   w_hit2;
    logic   w_load_use;
    logic   w_bubble;
    rec_t   w_id_rec;
    logic   w_unused_fields;

    assign w_mem_busy = r_mem.valid && !mem_ready &&
                        (r_mem.op == OP_LOAD || r_mem.op == OP_STORE);

    always_comb begin
        w_jump_cond = 1'b0;
        case (r_ex.op)
            OP_JUMP:   w_jump_cond = 1'b1;
            OP_JUMPL:  w_jump_cond = r_lf;
            OP_JUMPG:  w_jump_cond = r_gf;
            OP_JUMPE:  w_jump_cond = r_zf;
            OP_JUMPNE: w_jump_cond = !r_zf;
            default:   w_jump_cond = 1'b0;
        endcase
    end

    assign w_jump_hit = r_ex.valid && w_jump_cond;

    assign w_hit1 = id_use1 && (id_src1 == r_ex.dest);
    assign w_hit2 = id_use2 && (id_src2 == r_ex.dest);
    assign w_load_use = r_ex.valid && (r_ex.op == OP_LOAD) &&
                        id_valid && (w_hit1 || w_hit2);

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        w_bubble   = 1'b0;
        take_jump  = 1'b0;
        if (w_mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (w_jump_hit) begin
            take_jump  = 1'b1;
            ifid_flush = 1'b1;
            w_bubble   = 1'b1;
        end else if (w_load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            w_bubble   = 1'b1;
        end
    end

    assign ex_bubble = w_bubble;

    assign w_id_rec = '{
        valid: id_valid & ~w_bubble,
        op:    id_op,
        dest:  id_dest,
        src1:  id_src1,
        src2:  id_src2,
        use1:  id_use1,
        use2:  id_use2
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
            r_zf  <= 1'b0;
            r_gf  <= 1'b0;
            r_lf  <= 1'b0;
        end else if (!w_mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_id_rec;
            if (r_ex.valid && r_ex.op == OP_CMP) begin
                r_zf <= ex_cmp_zero;
                r_lf <= ex_cmp_less;
                r_gf <= ex_cmp_greater;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_mem_busy)
                    w_state_nxt = S_HOLD;
                else if (w_load_use && !w_jump_hit)
                    w_state_nxt = S_STALL;
                else
                    w_state_nxt = S_RUN;
            end
            S_STALL:
                w_state_nxt = w_mem_busy ? S_HOLD : S_RUN;
            S_HOLD:
                w_state_nxt = w_mem_busy ? S_HOLD : S_RUN;
            default:
                w_state_nxt = S_RUN;
        endcase
    end

    assign fwd_a = f_fwd(r_ex.valid & r_ex.use1, r_ex.src1, r_mem, r_wb);
    assign fwd_b = f_fwd(r_ex.valid & r_ex.use2, r_ex.src2, r_mem, r_wb);

    assign wb_we   = r_wb.valid && f_writes(r_wb.op) && !w_mem_busy;
    assign wb_dest = r_wb.dest;

    assign zf    = r_zf;
    assign gf    = r_gf;
    assign lf    = r_lf;
    assign state = r_state;

    // Source fields ride along past EX but are only consumed there.
    assign w_unused_fields = ^{r_mem.src1, r_mem.src2, r_mem.use1,
                               r_mem.use2, r_wb.src1, r_wb.src2,
                               r_wb.use1, r_wb.use2};

endmodule
